// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: opcodes, widths, EX->MEM bundle.
package ex_stage_pkg;

    localparam int unsigned D_SIZE        = 32;
    localparam int unsigned ADDR_LINE_REG = 5;
    localparam int unsigned OP_SIZE       = 6;
    localparam int unsigned MUL_STEP      = 8;
    localparam int unsigned MUL_CNT_W     = 2;

    typedef enum logic [OP_SIZE-1:0] {
        OP_ADD  = 6'b000000,
        OP_ADDI = 6'b000001,
        OP_SUB  = 6'b000010,
        OP_SUBI = 6'b000011,
        OP_MUL  = 6'b000100,
        OP_MULI = 6'b000101,
        OP_OR   = 6'b000110,
        OP_ORI  = 6'b000111,
        OP_AND  = 6'b001000,
        OP_ANDI = 6'b001001,
        OP_XOR  = 6'b001010,
        OP_XORI = 6'b001011,
        OP_LDW  = 6'b001100,
        OP_STW  = 6'b001101,
        OP_BZ   = 6'b001110,
        OP_BEQ  = 6'b001111,
        OP_JR   = 6'b010000,
        OP_HALT = 6'b010001
    } opcode_e;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    typedef struct packed {
        logic [D_SIZE-1:0]        alu_result;
        logic [D_SIZE-1:0]        store_data;
        logic [ADDR_LINE_REG-1:0] rd_add;
        logic                     reg_write;
        logic                     mem_read;
        logic                     mem_to_reg;
        logic                     mem_write;
    } ex_mem_t;

    localparam ex_mem_t EX_MEM_BUBBLE = '0;

    // PC-relative branch target: word-scaled immediate added to PC+4.
    function automatic logic [D_SIZE-1:0] branch_target(input logic [D_SIZE-1:0] pc4,
                                                        input logic [D_SIZE-1:0] imm);
        return pc4 + (imm << 2);
    endfunction

endpackage

// File: rtl/ex_stage_mul.sv
// Iterative 32x32 multiplier, 8 multiplier bits per cycle, low 32 product bits.
module mul_iter
    import ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [D_SIZE-1:0] a,
    input  logic [D_SIZE-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [D_SIZE-1:0] product
);

    localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(D_SIZE / MUL_STEP - 1);

    mul_state_e           state;
    mul_state_e           state_nxt;
    logic [MUL_CNT_W-1:0] count;
    logic [D_SIZE-1:0]    a_q;
    logic [D_SIZE-1:0]    b_q;
    logic [D_SIZE-1:0]    acc_q;
    logic [D_SIZE-1:0]    partial;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= MUL_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MUL_IDLE: if (start)             state_nxt = MUL_BUSY;
            MUL_BUSY: if (count == CNT_LAST) state_nxt = MUL_IDLE;
        endcase
    end

    // Shift-and-accumulate datapath; operands captured when the FSM accepts start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (state == MUL_IDLE) begin
            if (start) begin
                count <= '0;
                a_q   <= a;
                b_q   <= b;
                acc_q <= '0;
            end
        end else begin
            count <= count + MUL_CNT_W'(1);
            a_q   <= a_q << MUL_STEP;
            b_q   <= b_q >> MUL_STEP;
            acc_q <= product;
        end
    end

    // product includes the current cycle's partial so the final sum is ready on the last BUSY cycle.
    always_comb begin
        partial = D_SIZE'(a_q * D_SIZE'(b_q[MUL_STEP-1:0]));
        busy    = (state == MUL_BUSY);
        done    = busy && (count == CNT_LAST);
        product = acc_q + partial;
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, address generation, branch resolution, iterative multiply and halt.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [OP_SIZE-1:0]       opcode_f_id,
    input  logic [D_SIZE-1:0]        pc_f_id,
    input  logic [D_SIZE-1:0]        pc4_f_id,
    input  logic [D_SIZE-1:0]        rs_reg_value_f_id,
    input  logic [D_SIZE-1:0]        rt_reg_value_f_id,
    input  logic [ADDR_LINE_REG-1:0] rd_add_value_f_id,
    input  logic [D_SIZE-1:0]        i_data_f_id,
    input  logic                     branch_f_id,
    input  logic                     mem_read_f_id,
    input  logic                     mem_to_reg_f_id,
    input  logic                     mem_write_f_id,
    output logic [D_SIZE-1:0]        alu_result_2_mem,
    output logic [D_SIZE-1:0]        store_data_2_mem,
    output logic [ADDR_LINE_REG-1:0] rd_add_2_mem,
    output logic                     reg_write_2_mem,
    output logic                     mem_read_2_mem,
    output logic                     mem_to_reg_2_mem,
    output logic                     mem_write_2_mem,
    output logic                     branch_taken_2_if,
    output logic [D_SIZE-1:0]        branch_target_2_if,
    output logic                     stall_2_id,
    output logic                     halt_2_mem
);

    ex_mem_t                  ex_mem_q;
    ex_mem_t                  ex_mem_nxt;
    logic                     taken_q;
    logic                     taken_nxt;
    logic [D_SIZE-1:0]        target_q;
    logic [D_SIZE-1:0]        target_nxt;
    logic                     halt_q;
    logic                     halt_nxt;
    logic [ADDR_LINE_REG-1:0] mul_rd;
    logic                     live;
    logic                     is_mul;
    logic                     accept;
    logic                     mul_busy;
    logic                     mul_done;
    logic [D_SIZE-1:0]        mul_product;
    logic [D_SIZE-1:0]        alu_b;
    logic [D_SIZE-1:0]        alu_out;
    logic                     unused_inputs;

    // PC and the ID branch hint are not needed: the opcode alone resolves control flow.
    assign unused_inputs = ^{pc_f_id, branch_f_id};

    // A taken branch in the output register squashes the instruction now in ID.
    assign live       = !halt_q && !taken_q;
    assign is_mul     = (opcode_f_id == OP_MUL) || (opcode_f_id == OP_MULI);
    assign accept     = live && is_mul && !mul_busy;
    assign stall_2_id = accept || (mul_busy && !mul_done);
    assign alu_b      = opcode_f_id[0] ? i_data_f_id : rt_reg_value_f_id;

    mul_iter u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept),
        .a       (rs_reg_value_f_id),
        .b       (alu_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_out = '0;
        case (opcode_f_id)
            OP_ADD, OP_ADDI: alu_out = rs_reg_value_f_id + alu_b;
            OP_SUB, OP_SUBI: alu_out = rs_reg_value_f_id - alu_b;
            OP_OR,  OP_ORI:  alu_out = rs_reg_value_f_id | alu_b;
            OP_AND, OP_ANDI: alu_out = rs_reg_value_f_id & alu_b;
            OP_XOR, OP_XORI: alu_out = rs_reg_value_f_id ^ alu_b;
            OP_LDW, OP_STW:  alu_out = rs_reg_value_f_id + i_data_f_id;
            default:         alu_out = '0;
        endcase
    end

    // While the multiplier runs, ID holds the mul itself, so its inputs are ignored.
    always_comb begin
        ex_mem_nxt = EX_MEM_BUBBLE;
        taken_nxt  = 1'b0;
        target_nxt = '0;
        halt_nxt   = halt_q;
        if (mul_busy) begin
            if (mul_done) begin
                ex_mem_nxt.alu_result = mul_product;
                ex_mem_nxt.rd_add     = mul_rd;
                ex_mem_nxt.reg_write  = 1'b1;
            end
        end else if (live) begin
            case (opcode_f_id)
                OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_OR, OP_ORI, OP_AND, OP_ANDI,
                OP_XOR, OP_XORI, OP_LDW, OP_STW: begin
                    ex_mem_nxt.alu_result = alu_out;
                    ex_mem_nxt.store_data = rt_reg_value_f_id;
                    ex_mem_nxt.rd_add     = rd_add_value_f_id;
                    ex_mem_nxt.reg_write  = (opcode_f_id != OP_STW);
                    ex_mem_nxt.mem_read   = mem_read_f_id;
                    ex_mem_nxt.mem_to_reg = mem_to_reg_f_id;
                    ex_mem_nxt.mem_write  = mem_write_f_id;
                end
                OP_BZ: begin
                    taken_nxt = (rs_reg_value_f_id == '0);
                    if (taken_nxt) target_nxt = branch_target(pc4_f_id, i_data_f_id);
                end
                OP_BEQ: begin
                    taken_nxt = (rs_reg_value_f_id == rt_reg_value_f_id);
                    if (taken_nxt) target_nxt = branch_target(pc4_f_id, i_data_f_id);
                end
                OP_JR: begin
                    taken_nxt  = 1'b1;
                    target_nxt = rs_reg_value_f_id;
                end
                OP_HALT: halt_nxt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_mem_q <= EX_MEM_BUBBLE;
            taken_q  <= 1'b0;
            target_q <= '0;
            halt_q   <= 1'b0;
            mul_rd   <= '0;
        end else begin
            ex_mem_q <= ex_mem_nxt;
            taken_q  <= taken_nxt;
            target_q <= target_nxt;
            halt_q   <= halt_nxt;
            if (accept) mul_rd <= rd_add_value_f_id;
        end
    end

    assign alu_result_2_mem   = ex_mem_q.alu_result;
    assign store_data_2_mem   = ex_mem_q.store_data;
    assign rd_add_2_mem       = ex_mem_q.rd_add;
    assign reg_write_2_mem    = ex_mem_q.reg_write;
    assign mem_read_2_mem     = ex_mem_q.mem_read;
    assign mem_to_reg_2_mem   = ex_mem_q.mem_to_reg;
    assign mem_write_2_mem    = ex_mem_q.mem_write;
    assign branch_taken_2_if  = taken_q;
    assign branch_target_2_if = target_q;
    assign halt_2_mem         = halt_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed + randomised scoreboard bench for ex_stage.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode_f_id;
    logic [31:0] pc_f_id, pc4_f_id, rs_reg_value_f_id, rt_reg_value_f_id, i_data_f_id;
    logic [4:0]  rd_add_value_f_id;
    logic        branch_f_id, mem_read_f_id, mem_to_reg_f_id, mem_write_f_id;
    logic [31:0] alu_result_2_mem, store_data_2_mem, branch_target_2_if;
    logic [4:0]  rd_add_2_mem;
    logic        reg_write_2_mem, mem_read_2_mem, mem_to_reg_2_mem, mem_write_2_mem;
    logic        branch_taken_2_if, stall_2_id, halt_2_mem;

    ex_stage dut (
        .clk                (clk),
        .reset              (reset),
        .opcode_f_id        (opcode_f_id),
        .pc_f_id            (pc_f_id),
        .pc4_f_id           (pc4_f_id),
        .rs_reg_value_f_id  (rs_reg_value_f_id),
        .rt_reg_value_f_id  (rt_reg_value_f_id),
        .rd_add_value_f_id  (rd_add_value_f_id),
        .i_data_f_id        (i_data_f_id),
        .branch_f_id        (branch_f_id),
        .mem_read_f_id      (mem_read_f_id),
        .mem_to_reg_f_id    (mem_to_reg_f_id),
        .mem_write_f_id     (mem_write_f_id),
        .alu_result_2_mem   (alu_result_2_mem),
        .store_data_2_mem   (store_data_2_mem),
        .rd_add_2_mem       (rd_add_2_mem),
        .reg_write_2_mem    (reg_write_2_mem),
        .mem_read_2_mem     (mem_read_2_mem),
        .mem_to_reg_2_mem   (mem_to_reg_2_mem),
        .mem_write_2_mem    (mem_write_2_mem),
        .branch_taken_2_if  (branch_taken_2_if),
        .branch_target_2_if (branch_target_2_if),
        .stall_2_id         (stall_2_id),
        .halt_2_mem         (halt_2_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] alu, store, target;
        logic [4:0]  rd;
        logic        rw, mr, mtr, mw, taken, halt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    logic [5:0] alu_ops [12] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13};

    function automatic logic [127:0] pack_v(input logic [31:0] alu, store, target, input logic [4:0] rd,
                                            input logic rw, mr, mtr, mw, taken, halt);
        return 128'({alu, store, target, rd, rw, mr, mtr, mw, taken, halt});
    endfunction

    function automatic logic [127:0] obs_now();
        return pack_v(alu_result_2_mem, store_data_2_mem, branch_target_2_if, rd_add_2_mem,
                      reg_write_2_mem, mem_read_2_mem, mem_to_reg_2_mem, mem_write_2_mem,
                      branch_taken_2_if, halt_2_mem);
    endfunction

    function automatic exp_t mk(input string tag, input logic [31:0] alu, store, input logic [4:0] rd,
                                input logic rw, mr, mtr, mw, taken, input logic [31:0] target,
                                input logic halt);
        exp_t e;
        e.tag = tag; e.alu = alu; e.store = store; e.rd = rd; e.rw = rw; e.mr = mr;
        e.mtr = mtr; e.mw = mw; e.taken = taken; e.target = target; e.halt = halt;
        return e;
    endfunction

    function automatic exp_t bubble(input string tag, input logic halt);
        return mk(tag, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, halt);
    endfunction

    // Independent reference for the single-cycle ALU/address ops.
    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] rs, rt, imm);
        logic [31:0] b;
        b = op[0] ? imm : rt;
        case (op)
            6'd0, 6'd1:   return rs + b;
            6'd2, 6'd3:   return rs - b;
            6'd6, 6'd7:   return rs | b;
            6'd8, 6'd9:   return rs & b;
            6'd10, 6'd11: return rs ^ b;
            6'd12, 6'd13: return rs + imm;
            default:      return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] rs, rt, imm, pc4,
                         input logic [4:0] rd, input logic mr, mtr, mw);
        opcode_f_id       = op;
        rs_reg_value_f_id = rs;
        rt_reg_value_f_id = rt;
        i_data_f_id       = imm;
        pc4_f_id          = pc4;
        pc_f_id           = pc4 - 32'd4;
        rd_add_value_f_id = rd;
        branch_f_id       = (op == OP_BZ) || (op == OP_BEQ);
        mem_read_f_id     = mr;
        mem_to_reg_f_id   = mtr;
        mem_write_f_id    = mw;
    endtask

    // One pipeline cycle: drive at negedge, check the combinational stall, compare the registered result.
    task automatic run(input logic [5:0] op, input logic [31:0] rs, rt, imm, pc4,
                       input logic [4:0] rd, input logic mr, mtr, mw,
                       input logic exp_stall, input exp_t e);
        exp_t got;
        @(negedge clk);
        drive(op, rs, rt, imm, pc4, rd, mr, mtr, mw);
        sb.push_back(e);
        #1;
        check($sformatf("%s/stall", e.tag), 128'(stall_2_id), 128'(exp_stall));
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check(got.tag, obs_now(), pack_v(got.alu, got.store, got.target, got.rd, got.rw, got.mr,
                                         got.mtr, got.mw, got.taken, got.halt));
    endtask

    task automatic mul_seq(input logic [5:0] op, input logic [31:0] rs, rt, imm,
                           input logic [4:0] rd, input logic [31:0] prod);
        for (int k = 0; k < 4; k++)
            run(op, rs, rt, imm, 32'd0, rd, 1'b0, 1'b0, 1'b0, 1'b1, bubble($sformatf("mul_bubble%0d", k), 1'b0));
        run(op, rs, rt, imm, 32'd0, rd, 1'b0, 1'b0, 1'b0, 1'b0,
            mk("mul_result", prod, 32'd0, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
    endtask

    initial begin
        reset = 1'b0;
        drive(6'h3F, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #3;
        check("reset_outputs", obs_now(), 128'd0);
        check("reset_stall", 128'(stall_2_id), 128'd0);
        @(negedge clk);
        reset = 1'b1;

        run(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0,
            mk("add_wrap", 32'd0, 32'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
        run(OP_STW, 32'h40, 32'hAB, 32'd8, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
            mk("stw", 32'h48, 32'hAB, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0));
        run(OP_LDW, 32'h100, 32'h5, 32'hFFFF_FFFC, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0,
            mk("ldw", 32'hFC, 32'h5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0));

        mul_seq(OP_MULI, 32'd7, 32'd0, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB);
        mul_seq(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF1, 32'd0, 5'd3, 32'(32'h1234_5678 * 32'h9ABC_DEF1));

        run(OP_BEQ, 32'd3, 32'd3, 32'd4, 32'h100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
            mk("beq_taken", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h110, 1'b0));
        run(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, bubble("beq_squash", 1'b0));
        run(OP_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0,
            mk("after_squash", 32'd3, 32'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));

        run(OP_JR, 32'h2000, 32'd0, 32'd0, 32'h300, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
            mk("jr", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 1'b0));
        run(OP_BZ, 32'd0, 32'd0, 32'd1, 32'h304, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, bubble("jr_squash_bz", 1'b0));
        run(OP_BZ, 32'd1, 32'd0, 32'd4, 32'h400, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, bubble("bz_not_taken", 1'b0));
        run(OP_SUB, 32'd1, 32'd2, 32'd0, 32'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0,
            mk("sub_after_nt", 32'hFFFF_FFFF, 32'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));
        run(OP_BZ, 32'd0, 32'd9, 32'hFFFF_FFFF, 32'h200, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
            mk("bz_back", 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1FC, 1'b0));
        run(OP_MUL, 32'd5, 32'd6, 32'd0, 32'd0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, bubble("squash_mul", 1'b0));
        run(6'h20, 32'd1, 32'd1, 32'd1, 32'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, bubble("unknown_op", 1'b0));

        for (int i = 0; i < 10; i++) begin
            logic [5:0]  op;
            logic [31:0] rs, rt, imm;
            logic [4:0]  rd;
            logic        mr, mtr, mw;
            op  = alu_ops[$urandom_range(0, 11)];
            rs  = $urandom; rt = $urandom; imm = $urandom;
            rd  = 5'($urandom); mr = 1'($urandom); mtr = 1'($urandom); mw = 1'($urandom);
            run(op, rs, rt, imm, 32'd0, rd, mr, mtr, mw, 1'b0,
                mk($sformatf("rand_op%0d", op), ref_alu(op, rs, rt, imm), rt, rd, op != 6'd13,
                   mr, mtr, mw, 1'b0, 32'd0, 1'b0));
        end

        // Abort a multiply during its second BUSY cycle.
        run(OP_MUL, 32'd5, 32'd6, 32'd0, 32'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, bubble("rst_mul_accept", 1'b0));
        run(OP_MUL, 32'd5, 32'd6, 32'd0, 32'd0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, bubble("rst_mul_busy0", 1'b0));
        @(negedge clk);
        drive(6'h3F, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_mid_outputs", obs_now(), 128'd0);
        check("rst_mid_stall", 128'(stall_2_id), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++)
            run(6'h3F, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                bubble($sformatf("post_rst_idle%0d", k), 1'b0));
        run(OP_XORI, 32'hF0F0_F0F0, 32'd0, 32'hFFFF_0000, 32'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0,
            mk("post_rst_xori", 32'h0F0F_F0F0, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0));

        run(OP_HALT, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, bubble("halt", 1'b1));
        run(OP_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, bubble("halted_add", 1'b1));
        run(OP_MUL, 32'd2, 32'd3, 32'd0, 32'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, bubble("halted_mul", 1'b1));
        run(OP_JR, 32'h40, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, bubble("halted_jr", 1'b1));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("halt_cleared", obs_now(), 128'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
